// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: 16 GPRs, PC, IR, MAR, MDR, Y, 64-bit Z, HI/LO,
// CON flip-flop, input/output ports and a combinational ALU. One source drives the
// shared bus per cycle (fixed priority); any set of destinations may latch it.
module datapath (
  input  logic        Clock,
  input  logic        Clear,
  input  logic        PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, InPortOut,
  input  logic        PCin, IRin, MARin, MDRin, Yin, ZLowIn, ZHighIn, HIin, LOin,
  input  logic        CONin, InPortIn, OutPortIn,
  input  logic        IncPC,
  input  logic        Read,
  input  logic        RAMin,
  input  logic        GRA, GRB, GRC,
  input  logic        Rin, Rout, BAout,
  input  logic [15:0] REGin,
  input  logic [15:0] REGout,
  output logic [4:0]  opcode,
  input  logic [31:0] Mdatain,
  input  logic [31:0] InPort_data,
  output logic [31:0] OutPort_data,
  output logic [31:0] bus
);

  logic [31:0] r_q [16];
  logic [31:0] pc_q, ir_q, mar_q, mdr_q, y_q, hi_q, lo_q, inport_q, outport_q;
  logic [63:0] z_q;
  logic        con_q;

  logic [31:0] bus_d;
  logic [63:0] alu_d;
  logic        con_d;
  logic [3:0]  sel_idx;
  logic [15:0] dec;
  logic [15:0] write_en, read_en;
  logic        ba_zero;
  logic        hit;
  logic [31:0] c_sext;
  logic [63:0] ror_w, rol_w, mul_w;
  logic [31:0] quot_w, rem_w;
  logic        unused_sink;

  // MAR only feeds external memory addressing; RAMin has no function here.
  assign unused_sink = ^{RAMin, mar_q};

  assign opcode       = ir_q[31:27];
  assign OutPort_data = outport_q;
  assign bus          = bus_d;
  assign c_sext       = {{13{ir_q[18]}}, ir_q[18:0]};

  // Register-field select: GRA beats GRB beats GRC; no select -> no decode.
  always_comb begin
    sel_idx = 4'd0;
    dec     = '0;
    if (GRA)      sel_idx = ir_q[26:23];
    else if (GRB) sel_idx = ir_q[22:19];
    else if (GRC) sel_idx = ir_q[18:15];
    if (GRA | GRB | GRC) dec[sel_idx] = 1'b1;
  end

  assign write_en = REGin | ({16{Rin}} & dec);
  assign read_en  = REGout | ({16{Rout | BAout}} & dec);
  // Base-address reads of R0 yield zero (R0 as "no base"), but plain reads see R0.
  assign ba_zero  = BAout & dec[0] & ~Rout & ~REGout[0];

  // Bus source mux: lowest-numbered GPR first, then HI, LO, ZHigh, ZLow, PC, MDR, InPort, C.
  always_comb begin
    bus_d = '0;
    hit   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!hit && read_en[i]) begin
        bus_d = (i == 0 && ba_zero) ? 32'h0 : r_q[i];
        hit   = 1'b1;
      end
    end
    if (!hit) begin
      if (HIout)          bus_d = hi_q;
      else if (LOout)     bus_d = lo_q;
      else if (ZHighout)  bus_d = z_q[63:32];
      else if (ZLowout)   bus_d = z_q[31:0];
      else if (PCout)     bus_d = pc_q;
      else if (MDRout)    bus_d = mdr_q;
      else if (InPortOut) bus_d = inport_q;
      else if (Cout)      bus_d = c_sext;
    end
  end

  assign ror_w  = {y_q, y_q} >> bus_d[4:0];
  assign rol_w  = {y_q, y_q} << bus_d[4:0];
  assign mul_w  = {{32{y_q[31]}}, y_q} * {{32{bus_d[31]}}, bus_d};
  assign quot_w = $signed(y_q) / $signed(bus_d);
  assign rem_w  = $signed(y_q) % $signed(bus_d);

  // ALU: A = Y, B = bus; IncPC overrides the opcode.
  always_comb begin
    alu_d = {32'h0, bus_d};
    if (IncPC) begin
      alu_d = {32'h0, bus_d + 32'd1};
    end else begin
      case (opcode)
        5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b01011,
        5'b10010, 5'b10011, 5'b10100: alu_d = {32'h0, y_q + bus_d};
        5'b00100:                     alu_d = {32'h0, y_q - bus_d};
        5'b01001, 5'b01100:           alu_d = {32'h0, y_q & bus_d};
        5'b01010, 5'b01101:           alu_d = {32'h0, y_q | bus_d};
        5'b00101:                     alu_d = {32'h0, y_q >> bus_d[4:0]};
        5'b00110:                     alu_d = {32'h0, y_q << bus_d[4:0]};
        5'b00111:                     alu_d = {32'h0, ror_w[31:0]};
        5'b01000:                     alu_d = {32'h0, rol_w[63:32]};
        5'b01110:                     alu_d = mul_w;
        5'b01111:                     alu_d = (bus_d == 32'h0) ? {y_q, 32'hFFFF_FFFF}
                                                               : {rem_w, quot_w};
        5'b10000:                     alu_d = {32'h0, 32'h0 - bus_d};
        5'b10001:                     alu_d = {32'h0, ~bus_d};
        default:                      alu_d = {32'h0, bus_d};
      endcase
    end
  end

  // Branch condition evaluated on the bus, selected by IR C2.
  always_comb begin
    con_d = 1'b0;
    case (ir_q[20:19])
      2'b00: con_d = (bus_d == 32'h0);
      2'b01: con_d = (bus_d != 32'h0);
      2'b10: con_d = ~bus_d[31];
      2'b11: con_d = bus_d[31];
      default: con_d = 1'b0;
    endcase
  end

  // All architectural registers; every enabled destination latches the same bus value.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
      pc_q      <= '0;
      ir_q      <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      y_q       <= '0;
      z_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      con_q     <= 1'b0;
      inport_q  <= '0;
      outport_q <= '0;
    end else begin
      for (int i = 0; i < 16; i++) if (write_en[i]) r_q[i] <= bus_d;
      if (PCin)      pc_q              <= bus_d;
      if (IRin)      ir_q              <= bus_d;
      if (MARin)     mar_q             <= bus_d;
      if (MDRin)     mdr_q             <= Read ? Mdatain : bus_d;
      if (Yin)       y_q               <= bus_d;
      if (ZLowIn)    z_q[31:0]         <= alu_d[31:0];
      if (ZHighIn)   z_q[63:32]        <= alu_d[63:32];
      if (HIin)      hi_q              <= bus_d;
      if (LOin)      lo_q              <= bus_d;
      if (CONin)     con_q             <= con_d;
      if (InPortIn)  inport_q          <= InPort_data;
      if (OutPortIn) outport_q         <= bus_d;
    end
  end

endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: directed bus/register sequences, a table of ALU vectors,
// and random ALU operations checked against an arithmetic reference model.
module tb_datapath;

  logic        Clock = 1'b0;
  logic        Clear;
  logic        PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, InPortOut;
  logic        PCin, IRin, MARin, MDRin, Yin, ZLowIn, ZHighIn, HIin, LOin;
  logic        CONin, InPortIn, OutPortIn, IncPC, Read, RAMin;
  logic        GRA, GRB, GRC, Rin, Rout, BAout;
  logic [15:0] REGin, REGout;
  logic [4:0]  opcode;
  logic [31:0] Mdatain, InPort_data, OutPort_data, bus;

  int n_vec = 0;
  int n_err = 0;

  datapath dut (
    .Clock(Clock), .Clear(Clear),
    .PCout(PCout), .ZLowout(ZLowout), .ZHighout(ZHighout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .Cout(Cout), .InPortOut(InPortOut),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin),
    .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .HIin(HIin), .LOin(LOin),
    .CONin(CONin), .InPortIn(InPortIn), .OutPortIn(OutPortIn),
    .IncPC(IncPC), .Read(Read), .RAMin(RAMin),
    .GRA(GRA), .GRB(GRB), .GRC(GRC), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .REGin(REGin), .REGout(REGout), .opcode(opcode),
    .Mdatain(Mdatain), .InPort_data(InPort_data),
    .OutPort_data(OutPort_data), .bus(bus)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clr();
    PCout = 0; ZLowout = 0; ZHighout = 0; MDRout = 0; HIout = 0; LOout = 0;
    Cout = 0; InPortOut = 0; PCin = 0; IRin = 0; MARin = 0; MDRin = 0; Yin = 0;
    ZLowIn = 0; ZHighIn = 0; HIin = 0; LOin = 0; CONin = 0; InPortIn = 0;
    OutPortIn = 0; IncPC = 0; Read = 0; RAMin = 0; GRA = 0; GRB = 0; GRC = 0;
    Rin = 0; Rout = 0; BAout = 0; REGin = '0; REGout = '0;
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic load_inport(input logic [31:0] v);
    clr();
    InPort_data = v;
    InPortIn = 1;
    step();
    clr();
  endtask

  // Reference ALU written straight from the operation list.
  function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input bit inc);
    int sa, sb, s, q, m;
    longint p;
    logic [31:0] r;
    sa = int'(a);
    sb = int'(b);
    s  = int'(b[4:0]);
    if (inc) return {32'h0, b + 32'd1};
    case (op)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd11, 5'd18, 5'd19, 5'd20: return {32'h0, a + b};
      5'd4:        return {32'h0, a - b};
      5'd9, 5'd12: return {32'h0, a & b};
      5'd10, 5'd13: return {32'h0, a | b};
      5'd5:        return {32'h0, a >> s};
      5'd6:        return {32'h0, a << s};
      5'd7: begin r = a; repeat (s) r = {r[0], r[31:1]}; return {32'h0, r}; end
      5'd8: begin r = a; repeat (s) r = {r[30:0], r[31]}; return {32'h0, r}; end
      5'd14: begin p = longint'(sa) * longint'(sb); return p; end
      5'd15: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        m = sa % sb;
        return {m, q};
      end
      5'd16: return {32'h0, 32'h0 - b};
      5'd17: return {32'h0, ~b};
      default: return {32'h0, b};
    endcase
  endfunction

  // IR <- opcode, Y <- a, Z <- ALU(a, bus=b), then read both Z halves on the bus.
  task automatic run_alu(input string nm, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit inc, input logic [63:0] exp);
    load_inport({op, 27'($urandom)});
    InPortOut = 1; IRin = 1; step(); clr();
    load_inport(a);
    InPortOut = 1; Yin = 1; step(); clr();
    load_inport(b);
    InPortOut = 1; IncPC = inc; ZLowIn = 1; ZHighIn = 1; step(); clr();
    ZLowout = 1; #1;
    chk({nm, "_lo"}, {32'h0, bus}, {32'h0, exp[31:0]});
    ZLowout = 0; ZHighout = 1; #1;
    chk({nm, "_hi"}, {32'h0, bus}, {32'h0, exp[63:32]});
    clr();
  endtask

  initial begin
    logic [4:0]  op;
    logic [31:0] a, b;
    bit          inc;

    tbl[0]  = '{5'b00011, 32'd3,          32'd4,          32'd7,          32'h0};
    tbl[1]  = '{5'b00100, 32'd5,          32'd7,          32'hFFFF_FFFE,  32'h0};
    tbl[2]  = '{5'b01001, 32'hF0F0_FFFF,  32'h0FF0_00FF,  32'h00F0_00FF,  32'h0};
    tbl[3]  = '{5'b01010, 32'hF000_0000,  32'h0000_000F,  32'hF000_000F,  32'h0};
    tbl[4]  = '{5'b00101, 32'h8000_0000,  32'h0000_0024,  32'h0800_0000,  32'h0};
    tbl[5]  = '{5'b00110, 32'h0000_0001,  32'h0000_001F,  32'h8000_0000,  32'h0};
    tbl[6]  = '{5'b00111, 32'h0000_0001,  32'h0000_0001,  32'h8000_0000,  32'h0};
    tbl[7]  = '{5'b01000, 32'h8000_0001,  32'h0000_0004,  32'h0000_0018,  32'h0};
    tbl[8]  = '{5'b01110, 32'hFFFF_FFFD,  32'd7,          32'hFFFF_FFEB,  32'hFFFF_FFFF};
    tbl[9]  = '{5'b01111, 32'd7,          32'd2,          32'd3,          32'd1};
    tbl[10] = '{5'b01111, 32'h1234_5678,  32'h0,          32'hFFFF_FFFF,  32'h1234_5678};
    tbl[11] = '{5'b01111, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
    tbl[12] = '{5'b10000, 32'd9,          32'd1,          32'hFFFF_FFFF,  32'h0};
    tbl[13] = '{5'b10001, 32'd9,          32'h0,          32'hFFFF_FFFF,  32'h0};
    tbl[14] = '{5'b10010, 32'd100,        32'h10,         32'h74,         32'h0};
    tbl[15] = '{5'b11111, 32'd1,          32'hDEAD_BEEF,  32'hDEAD_BEEF,  32'h0};
    tbl[16] = '{5'b01011, 32'hFFFF_FFFF,  32'd1,          32'h0,          32'h0};

    clr();
    Clear = 0; Mdatain = '0; InPort_data = '0;
    repeat (2) @(posedge Clock);
    #1;
    REGout = 16'h8000; #1;
    chk("rst_r15", {32'h0, bus}, 64'h0);
    clr(); #1;
    chk("rst_bus", {32'h0, bus}, 64'h0);
    chk("rst_outport", {32'h0, OutPort_data}, 64'h0);
    chk("rst_opcode", {59'h0, opcode}, 64'h0);
    chk("rst_pc", {32'h0, dut.pc_q}, 64'h0);
    chk("rst_z", dut.z_q, 64'h0);
    chk("rst_con", {63'h0, dut.con_q}, 64'h0);
    Clear = 1;
    step();

    // Fetch
    PCout = 1; MARin = 1; IncPC = 1; ZLowIn = 1; step(); clr();
    chk("fetch_mar0", {32'h0, dut.mar_q}, 64'h0);
    ZLowout = 1; #1;
    chk("fetch_z1", {32'h0, bus}, 64'h1);
    PCin = 1; step(); clr();
    PCout = 1; MARin = 1; #1;
    chk("fetch_pc1", {32'h0, bus}, 64'h1);
    step(); clr();
    chk("fetch_mar1", {32'h0, dut.mar_q}, 64'h1);

    // Memory read into MDR, then IR
    Mdatain = 32'd5; Read = 1; MDRin = 1; step(); clr();
    Mdatain = 32'hFFFF_FFFF;
    MDRout = 1; IRin = 1; #1;
    chk("mdr_bus", {32'h0, bus}, 64'h5);
    step(); clr();
    chk("ir_opcode", {59'h0, opcode}, 64'h0);
    Cout = 1; #1;
    chk("ir_c", {32'h0, bus}, 64'h5);
    clr();

    // Immediate add into R0, then R0 read variants
    GRB = 1; Rout = 1; Yin = 1; step(); clr();
    Cout = 1; ZLowIn = 1; step(); clr();
    ZLowout = 1; GRA = 1; Rin = 1; step(); clr();
    REGout = 16'h0001; #1;
    chk("r0_write", {32'h0, bus}, 64'h5);
    clr(); GRA = 1; Rout = 1; #1;
    chk("rout_r0", {32'h0, bus}, 64'h5);
    clr(); GRA = 1; BAout = 1; #1;
    chk("baout_r0", {32'h0, bus}, 64'h0);
    clr();

    // Input port -> R3 -> output port; CON with C2=00
    load_inport(32'hAA);
    InPortOut = 1; REGin = 16'h0008; step(); clr();
    REGout = 16'h0008; OutPortIn = 1; step(); clr();
    chk("outport", {32'h0, OutPort_data}, 64'hAA);
    CONin = 1; #1;
    chk("idle_bus", {32'h0, bus}, 64'h0);
    step(); clr();
    chk("con_eq0_t", {63'h0, dut.con_q}, 64'h1);
    REGout = 16'h0008; CONin = 1; step(); clr();
    chk("con_eq0_f", {63'h0, dut.con_q}, 64'h0);

    // Bus priority and simultaneous loads
    REGout = 16'h0009; #1;
    chk("prio_r0_r3", {32'h0, bus}, 64'h5);
    load_inport(32'h1234);
    InPortOut = 1; HIin = 1; LOin = 1; Yin = 1; step(); clr();
    HIout = 1; #1;
    chk("multi_hi", {32'h0, bus}, 64'h1234);
    clr(); LOout = 1; ZLowout = 1; #1;
    chk("multi_lo", {32'h0, bus}, 64'h1234);
    clr(); REGout = 16'h0008; HIout = 1; #1;
    chk("prio_reg_hi", {32'h0, bus}, 64'hAA);
    clr(); MDRout = 1; InPortOut = 1; Cout = 1; #1;
    chk("prio_mdr_in", {32'h0, bus}, 64'h5);
    clr();

    // Field select priority, C2=10, sign extension
    load_inport(32'h0091_8000);
    InPortOut = 1; IRin = 1; step(); clr();
    load_inport(32'h77);
    InPortOut = 1; GRA = 1; GRB = 1; Rin = 1; step(); clr();
    REGout = 16'h0002; #1;
    chk("gra_wins", {32'h0, bus}, 64'h77);
    clr(); REGout = 16'h0004; #1;
    chk("grb_nowrite", {32'h0, bus}, 64'h0);
    clr(); GRC = 1; Rout = 1; #1;
    chk("grc_read", {32'h0, bus}, 64'hAA);
    clr(); Cout = 1; CONin = 1; #1;
    chk("c_pos", {32'h0, bus}, 64'h0001_8000);
    step(); clr();
    chk("con_pos_t", {63'h0, dut.con_q}, 64'h1);
    load_inport(32'h8000_0000);
    InPortOut = 1; CONin = 1; step(); clr();
    chk("con_pos_f", {63'h0, dut.con_q}, 64'h0);
    load_inport(32'h0004_0000);
    InPortOut = 1; IRin = 1; step(); clr();
    Cout = 1; #1;
    chk("c_sext", {32'h0, bus}, 64'hFFFC_0000);
    clr();

    for (int i = 0; i < 17; i++)
      run_alu($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, 1'b0,
              {tbl[i].hi, tbl[i].lo});

    for (int i = 0; i < 60; i++) begin
      op  = 5'($urandom_range(0, 31));
      a   = $urandom;
      b   = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      inc = ($urandom_range(0, 9) == 0);
      if (op == 5'd15 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      run_alu($sformatf("rnd%0d_op%0d", i, op), op, a, b, inc, model(op, a, b, inc));
    end

    // Asynchronous reset in the middle of a transfer
    load_inport(32'h55);
    InPortOut = 1; PCin = 1; OutPortIn = 1; ZLowIn = 1; CONin = 1;
    #2 Clear = 0;
    #1 clr();
    REGout = 16'h0008; #1;
    chk("mid_rst_r3", {32'h0, bus}, 64'h0);
    chk("mid_rst_out", {32'h0, OutPort_data}, 64'h0);
    chk("mid_rst_op", {59'h0, opcode}, 64'h0);
    chk("mid_rst_pc", {32'h0, dut.pc_q}, 64'h0);
    chk("mid_rst_z", dut.z_q, 64'h0);
    clr();
    step();
    Clear = 1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
